// File: rtl/ins_sequencer_pkg.sv
// Shared opcode, field-position and state definitions for the instruction sequencer.
// Word layout: [15:14] opcode, [13:12] decoder channel select, [11:0] payload.
package ins_sequencer_pkg;

    localparam logic [1:0] OP_EMIT  = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_JUMP  = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned SEL_MSB = 13;
    localparam int unsigned PAY_MSB = 11;
    localparam int unsigned PAY_W   = PAY_MSB + 1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StEmit   = 3'd3,
        StDelay  = 3'd4,
        StHalt   = 3'd5
    } seq_state_e;

    function automatic logic [1:0] get_opcode(input logic [15:0] word);
        return word[OPC_MSB -: 2];
    endfunction

    function automatic logic [PAY_W-1:0] get_payload(input logic [15:0] word);
        return word[PAY_MSB:0];
    endfunction

endpackage

// File: rtl/ins_sequencer_delay_cnt.sv
// seq_delay_cnt: 12-bit loadable down-counter with zero flag, used for delay opcodes.
// Decrement saturates at zero so a stray dec cannot wrap the count.
module seq_delay_cnt
    import ins_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PAY_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [PAY_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - PAY_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ins_sequencer.sv
// Instruction sequencer: fetches words from a synchronous ROM, runs delay/jump/halt locally
// and hands emit words to the decoder over valid/ready. Option macro: SEQ_INS_HOLD_EN.
module ins_sequencer
    import ins_sequencer_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rdata,
    output logic [15:0]   ins,
    output logic          ins_valid,
    input  logic          ins_ready,
    output logic          busy,
    output logic          halted
);

    localparam logic [AW-1:0] START_PC = AW'(START_ADDR);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic [15:0]   ins_q, ins_d;
    logic          valid_q, valid_d;
    logic          rd_en_q, busy_q, halted_q;
    logic          cnt_load, cnt_dec, cnt_zero;

    assign pc_inc = pc_q + AW'(1);

    seq_delay_cnt u_delay_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (get_payload(mem_rdata)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        valid_d  = valid_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d    = START_PC;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                unique case (get_opcode(mem_rdata))
                    OP_EMIT: begin
                        ins_d   = mem_rdata;
                        valid_d = 1'b1;
                        state_d = StEmit;
                    end
                    OP_DELAY: begin
                        cnt_load = 1'b1;
                        state_d  = StDelay;
                    end
                    OP_JUMP: begin
                        pc_d    = mem_rdata[AW-1:0];
                        state_d = StFetch;
                    end
                    OP_HALT: state_d = StHalt;
                endcase
            end
            StEmit: begin
                if (ins_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_inc;
                    state_d = StFetch;
`ifndef SEQ_INS_HOLD_EN
                    ins_d   = '0;
`endif
                end
            end
            StDelay: begin
                if (cnt_zero) begin
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= START_PC;
            ins_q    <= '0;
            valid_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            valid_q  <= valid_d;
            rd_en_q  <= (state_d == StFetch);
            busy_q   <= (state_d != StIdle) && (state_d != StHalt);
            halted_q <= (state_d == StHalt);
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = pc_q;
    assign ins       = ins_q;
    assign ins_valid = valid_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_ins_sequencer.sv
// Self-checking bench for ins_sequencer (AW=4) with a behavioural synchronous ROM.
// Expected ins after a handshake follows SEQ_INS_HOLD_EN.
module tb_ins_sequencer;

    localparam int unsigned AW = 4;
`ifdef SEQ_INS_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          ins_ready = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata = '0;
    logic [15:0]   ins;
    logic          ins_valid;
    logic          busy;
    logic          halted;

    logic [15:0] rom [16];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= rom[mem_addr];

    ins_sequencer #(.AW(AW), .START_ADDR(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .busy      (busy),
        .halted    (halted)
    );

    typedef struct {
        logic        start;
        logic        ready;
        logic        rd_en;
        logic [3:0]  addr;
        logic        valid;
        logic [15:0] ins;
        logic        busy;
        logic        halted;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, " rd_en"},  32'(mem_rd_en), 32'(v.rd_en));
        check({tag, " addr"},   32'(mem_addr),  32'(v.addr));
        check({tag, " valid"},  32'(ins_valid), 32'(v.valid));
        check({tag, " ins"},    32'(ins),       32'(v.ins));
        check({tag, " busy"},   32'(busy),      32'(v.busy));
        check({tag, " halted"}, 32'(halted),    32'(v.halted));
    endtask

    task automatic check_zero(input string tag);
        vec_t z;
        z = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0};
        check_outs(tag, z);
    endtask

    task automatic do_reset();
        start     = 1'b0;
        ins_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_zero("reset");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_delay(input logic [11:0] pay, input bit poke);
        int n;
        int m;
        do_reset();
        rom[0] = {4'h4, pay};
        rom[1] = 16'h3001;
        rom[2] = 16'hC000;
        ins_ready = 1'b1;
        pulse_start();
        step();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            start = poke && (n == 1);
            step();
            start = 1'b0;
            if (mem_rd_en) break;
            n++;
        end
        check("delay cycles", 32'(n), 32'(int'(pay) + 1));
        check("delay exit addr", 32'(mem_addr), 32'd1);
        // Edges from the delay DECODE until ins_valid is first seen.
        m = n + 1;
        for (int k = 0; k < 10 && !ins_valid; k++) begin
            step();
            m++;
        end
        check("delay emit latency", 32'(m), 32'(int'(pay) + 4));
        check("delay emit ins", 32'(ins), 32'h3001);
        step();
        step();
        step();
        check("delay halted", 32'(halted), 32'd1);
        check("delay halt pc", 32'(mem_addr), 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        #2;
        do_reset();

        // Emit stream, one vector per clock edge.
        rom[0] = 16'h1ABC;
        rom[1] = 16'h2123;
        rom[2] = 16'hC000;
        vecs[0] = '{1, 1, 1, 4'd0, 0, 16'h0, 1, 0};
        vecs[1] = '{0, 1, 0, 4'd0, 0, 16'h0, 1, 0};
        vecs[2] = '{0, 1, 0, 4'd0, 1, 16'h1ABC, 1, 0};
        vecs[3] = '{0, 1, 1, 4'd1, 0, HOLD ? 16'h1ABC : 16'h0, 1, 0};
        vecs[4] = '{0, 1, 0, 4'd1, 0, HOLD ? 16'h1ABC : 16'h0, 1, 0};
        vecs[5] = '{0, 1, 0, 4'd1, 1, 16'h2123, 1, 0};
        vecs[6] = '{0, 1, 1, 4'd2, 0, HOLD ? 16'h2123 : 16'h0, 1, 0};
        vecs[7] = '{0, 1, 0, 4'd2, 0, HOLD ? 16'h2123 : 16'h0, 1, 0};
        vecs[8] = '{0, 1, 0, 4'd2, 0, HOLD ? 16'h2123 : 16'h0, 0, 1};
        vecs[9] = '{0, 1, 0, 4'd2, 0, HOLD ? 16'h2123 : 16'h0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            start     = vecs[i].start;
            ins_ready = vecs[i].ready;
            step();
            check_outs($sformatf("stream[%0d]", i), vecs[i]);
        end
        start = 1'b0;

        // Backpressure: ready held low for five EMIT cycles.
        do_reset();
        rom[0] = 16'h0055;
        rom[1] = 16'hC000;
        pulse_start();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check($sformatf("bp valid[%0d]", i), 32'(ins_valid), 32'd1);
            check($sformatf("bp ins[%0d]", i), 32'(ins), 32'h0055);
            check($sformatf("bp rd_en[%0d]", i), 32'(mem_rd_en), 32'd0);
        end
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        check("bp post valid", 32'(ins_valid), 32'd0);
        check("bp post rd_en", 32'(mem_rd_en), 32'd1);
        check("bp post addr", 32'(mem_addr), 32'd1);
        check("bp post ins", 32'(ins), HOLD ? 32'h0055 : 32'h0);
        step();
        step();
        check("bp halted", 32'(halted), 32'd1);
        check("bp halt pc", 32'(mem_addr), 32'd1);

        // Delay payload 3 (start poked mid-delay must be ignored) and payload 0.
        run_delay(12'd3, 1'b0);
        run_delay(12'd3, 1'b1);
        run_delay(12'd0, 1'b0);

        // Jump to the top address, emit there, then wrap to 0.
        do_reset();
        rom[0]  = 16'h800F;
        rom[15] = 16'h0001;
        ins_ready = 1'b1;
        pulse_start();
        check("jmp first addr", 32'(mem_addr), 32'd0);
        step();
        step();
        check("jmp target rd_en", 32'(mem_rd_en), 32'd1);
        check("jmp target addr", 32'(mem_addr), 32'd15);
        step();
        step();
        check("jmp emit valid", 32'(ins_valid), 32'd1);
        check("jmp emit ins", 32'(ins), 32'h0001);
        step();
        check("wrap rd_en", 32'(mem_rd_en), 32'd1);
        check("wrap addr", 32'(mem_addr), 32'd0);

        // Jump payload bits above AW are ignored.
        do_reset();
        rom[0] = 16'h8FFF;
        pulse_start();
        step();
        step();
        check("jmp trunc rd_en", 32'(mem_rd_en), 32'd1);
        check("jmp trunc addr", 32'(mem_addr), 32'd15);

        // Asynchronous reset while an emit is pending.
        do_reset();
        rom[0] = 16'h0055;
        pulse_start();
        step();
        step();
        check("rst pre valid", 32'(ins_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("rst async");
        step();
        rst_n = 1'b1;
        ins_ready = 1'b1;
        step();
        step();
        check("rst idle busy", 32'(busy), 32'd0);
        check("rst idle rd_en", 32'(mem_rd_en), 32'd0);
        check("rst idle valid", 32'(ins_valid), 32'd0);
        pulse_start();
        check("rst restart rd_en", 32'(mem_rd_en), 32'd1);
        check("rst restart addr", 32'(mem_addr), 32'd0);
        check("rst restart busy", 32'(busy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
